// File: rtl/bpu_update_ctrl.sv
// bpu_update_ctrl
//
// Buffers resolved control-flow outcomes from two execute pipes and retires them to the
// branch predictor tables (BHT/JHT) at most one write per cycle. After reset it first sweeps
// every table index with a clear strobe. It also offers a drain handshake so that fences and
// mode switches can wait for all pending table writes to land.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   u0_* / u1_*        resolved outcomes from pipe 0 / pipe 1 (u1 is younger than u0)
//   upd_ready          both update ports may present this cycle (combinational)
//   stall              table write port busy: hold the current write, dequeue nothing
//   drain_req          stop accepting updates and empty the FIFO
//   drain_done         FIFO empty while draining
//   wr_valid, wr_*     registered table write (head of FIFO from the previous cycle)
//   init_we, init_idx  clear strobe and index during the post-reset sweep
//   drop_cnt           saturating count of updates presented while upd_ready was low
module bpu_update_ctrl #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned IDX_BITS = 7
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                u0_valid,
    input  logic [31:0]         u0_pc,
    input  logic [31:0]         u0_dest,
    input  logic [1:0]          u0_kind,
    input  logic                u0_taken,

    input  logic                u1_valid,
    input  logic [31:0]         u1_pc,
    input  logic [31:0]         u1_dest,
    input  logic [1:0]          u1_kind,
    input  logic                u1_taken,

    output logic                upd_ready,
    input  logic                stall,
    input  logic                drain_req,
    output logic                drain_done,

    output logic                wr_valid,
    output logic [31:0]         wr_pc,
    output logic [31:0]         wr_dest,
    output logic [1:0]          wr_kind,
    output logic                wr_taken,

    output logic                init_we,
    output logic [IDX_BITS-1:0] init_idx,
    output logic [7:0]          drop_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StDrain
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e               state_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [IDX_BITS-1:0]  init_idx_q;
    logic [7:0]           drop_cnt_q;

    logic                 wr_valid_q;
    logic [31:0]          wr_pc_q;
    logic [31:0]          wr_dest_q;
    logic [1:0]           wr_kind_q;
    logic                 wr_taken_q;

    // FIFO payload storage; contents are only meaningful between rd_ptr and wr_ptr
    logic [31:0]          pc_mem    [DEPTH];
    logic [31:0]          dest_mem  [DEPTH];
    logic [1:0]           kind_mem  [DEPTH];
    logic                 taken_mem [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                 ready_c;
    logic                 enq0;
    logic                 enq1;
    logic [PTR_W-1:0]     u1_slot;
    logic [CNT_W-1:0]     enq_num;
    logic                 deq;
    logic [1:0]           drop_inc;
    logic [8:0]           drop_sum;
    logic [7:0]           drop_cnt_d;
    logic [CNT_W-1:0]     free_slots;

    always_comb begin
        free_slots = CNT_W'(DEPTH) - count_q;

        // Both ports must fit, so readiness needs two free slots regardless of how
        // many ports end up valid. A same-cycle dequeue is deliberately not credited.
        ready_c = (state_q == StRun) && (free_slots >= CNT_W'(2));

        enq0 = ready_c && u0_valid;
        enq1 = ready_c && u1_valid;

        // u1 packs directly behind u0, or into u0's slot when u0 is idle
        u1_slot = wr_ptr_q + PTR_W'(enq0);
        enq_num = CNT_W'(enq0) + CNT_W'(enq1);

        // Count is from before this cycle's enqueue, so a new entry waits one cycle
        deq = (count_q != '0) && (state_q != StInit) && !stall;

        drop_inc = 2'b00;
        if (!ready_c) begin
            drop_inc = {1'b0, u0_valid} + {1'b0, u1_valid};
        end
        drop_sum   = {1'b0, drop_cnt_q} + {7'b0, drop_inc};
        drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // ------------------------------------------------------------------
    // FSM, FIFO control and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StInit;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            init_idx_q <= '0;
            drop_cnt_q <= '0;
            wr_valid_q <= 1'b0;
            wr_pc_q    <= '0;
            wr_dest_q  <= '0;
            wr_kind_q  <= '0;
            wr_taken_q <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    // Index wraps back to 0 as the sweep finishes
                    init_idx_q <= init_idx_q + 1'b1;
                    if (init_idx_q == {IDX_BITS{1'b1}}) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (drain_req) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!drain_req) begin
                        state_q <= StRun;
                    end
                end
                default: begin
                    state_q <= StInit;
                end
            endcase

            wr_ptr_q   <= wr_ptr_q + PTR_W'(enq_num);
            rd_ptr_q   <= rd_ptr_q + PTR_W'(deq);
            count_q    <= count_q + enq_num - CNT_W'(deq);
            drop_cnt_q <= drop_cnt_d;

            // Stall freezes the write port outright; the sweep ignores it
            if (deq) begin
                wr_valid_q <= 1'b1;
                wr_pc_q    <= pc_mem[rd_ptr_q];
                wr_dest_q  <= dest_mem[rd_ptr_q];
                wr_kind_q  <= kind_mem[rd_ptr_q];
                wr_taken_q <= taken_mem[rd_ptr_q];
            end else if (!stall || (state_q == StInit)) begin
                wr_valid_q <= 1'b0;
            end
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (enq0) begin
            pc_mem[wr_ptr_q]    <= u0_pc;
            dest_mem[wr_ptr_q]  <= u0_dest;
            kind_mem[wr_ptr_q]  <= u0_kind;
            taken_mem[wr_ptr_q] <= u0_taken;
        end
        if (enq1) begin
            pc_mem[u1_slot]    <= u1_pc;
            dest_mem[u1_slot]  <= u1_dest;
            kind_mem[u1_slot]  <= u1_kind;
            taken_mem[u1_slot] <= u1_taken;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign upd_ready  = ready_c;
    assign drain_done = (state_q == StDrain) && (count_q == '0);
    assign init_we    = (state_q == StInit);
    assign init_idx   = init_idx_q;
    assign drop_cnt   = drop_cnt_q;

    assign wr_valid   = wr_valid_q;
    assign wr_pc      = wr_pc_q;
    assign wr_dest    = wr_dest_q;
    assign wr_kind    = wr_kind_q;
    assign wr_taken   = wr_taken_q;

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Randomised bench for bpu_update_ctrl with a queue-based reference model. Inputs are driven
// on the falling edge; outputs are compared against the model on the same falling edge,
// before the model absorbs the inputs the DUT will sample on the next rising edge.
module tb_bpu_update_ctrl;

    localparam int DEPTH    = 4;
    localparam int IDX_BITS = 7;
    localparam int SWEEP    = 1 << IDX_BITS;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dest;
        logic [1:0]  kind;
        logic        taken;
    } ent_t;

    logic                clk;
    logic                reset;
    logic                u0_valid, u1_valid;
    logic [31:0]         u0_pc, u0_dest, u1_pc, u1_dest;
    logic [1:0]          u0_kind, u1_kind;
    logic                u0_taken, u1_taken;
    logic                upd_ready;
    logic                stall;
    logic                drain_req;
    logic                drain_done;
    logic                wr_valid;
    logic [31:0]         wr_pc, wr_dest;
    logic [1:0]          wr_kind;
    logic                wr_taken;
    logic                init_we;
    logic [IDX_BITS-1:0] init_idx;
    logic [7:0]          drop_cnt;

    bpu_update_ctrl #(
        .DEPTH   (DEPTH),
        .IDX_BITS(IDX_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .u0_valid  (u0_valid),
        .u0_pc     (u0_pc),
        .u0_dest   (u0_dest),
        .u0_kind   (u0_kind),
        .u0_taken  (u0_taken),
        .u1_valid  (u1_valid),
        .u1_pc     (u1_pc),
        .u1_dest   (u1_dest),
        .u1_kind   (u1_kind),
        .u1_taken  (u1_taken),
        .upd_ready (upd_ready),
        .stall     (stall),
        .drain_req (drain_req),
        .drain_done(drain_done),
        .wr_valid  (wr_valid),
        .wr_pc     (wr_pc),
        .wr_dest   (wr_dest),
        .wr_kind   (wr_kind),
        .wr_taken  (wr_taken),
        .init_we   (init_we),
        .init_idx  (init_idx),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: remaining sweep cycles, a draining flag, a plain queue of pending
    // updates, the last presented write and the drop tally.
    int   sweep_left = 0;
    bit   draining   = 1'b0;
    ent_t q[$];
    bit   m_wr_valid = 1'b0;
    ent_t m_wr;
    int   m_drops    = 0;
    bit   checking   = 1'b0;

    // Directed payload override for the next step
    bit   use_force  = 1'b0;
    ent_t force0, force1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (sweep_left == 0) && !draining && ((DEPTH - q.size()) >= 2);
    endfunction

    task automatic compare_outputs();
        bit sweeping;
        sweeping = (sweep_left > 0);
        check("init_we",    64'(init_we),    64'(sweeping));
        check("init_idx",   64'(init_idx),   sweeping ? 64'(SWEEP - sweep_left) : 64'd0);
        check("upd_ready",  64'(upd_ready),  64'(model_ready()));
        check("drain_done", 64'(drain_done), 64'(draining && (q.size() == 0)));
        check("wr_valid",   64'(wr_valid),   64'(m_wr_valid));
        check("drop_cnt",   64'(drop_cnt),   64'(m_drops));
        if (m_wr_valid) begin
            check("wr_pc",    64'(wr_pc),    64'(m_wr.pc));
            check("wr_dest",  64'(wr_dest),  64'(m_wr.dest));
            check("wr_kind",  64'(wr_kind),  64'(m_wr.kind));
            check("wr_taken", 64'(wr_taken), 64'(m_wr.taken));
        end
    endtask

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_step();
        bit   sweeping, ready, popped;
        ent_t e0, e1;
        if (reset) begin
            sweep_left = SWEEP;
            draining   = 1'b0;
            q.delete();
            m_wr_valid = 1'b0;
            m_drops    = 0;
            return;
        end
        sweeping = (sweep_left > 0);
        ready    = model_ready();
        popped   = 1'b0;
        if (!sweeping && !stall && (q.size() > 0)) begin
            m_wr       = q.pop_front();
            m_wr_valid = 1'b1;
            popped     = 1'b1;
        end
        if (!popped && (!stall || sweeping)) m_wr_valid = 1'b0;
        e0 = '{pc: u0_pc, dest: u0_dest, kind: u0_kind, taken: u0_taken};
        e1 = '{pc: u1_pc, dest: u1_dest, kind: u1_kind, taken: u1_taken};
        if (ready) begin
            if (u0_valid) q.push_back(e0);
            if (u1_valid) q.push_back(e1);
        end else begin
            m_drops = m_drops + int'(u0_valid) + int'(u1_valid);
            if (m_drops > 255) m_drops = 255;
        end
        if (sweeping) sweep_left--;
        else if (!draining && drain_req) draining = 1'b1;
        else if (draining && !drain_req) draining = 1'b0;
    endtask

    task automatic step(input bit rst, input bit v0, input bit v1, input bit st, input bit dr);
        @(negedge clk);
        reset     = rst;
        u0_valid  = v0;
        u1_valid  = v1;
        stall     = st;
        drain_req = dr;
        if (use_force) begin
            {u0_pc, u0_dest, u0_kind, u0_taken} = force0;
            {u1_pc, u1_dest, u1_kind, u1_taken} = force1;
            use_force = 1'b0;
        end else begin
            u0_pc    = $urandom;
            u0_dest  = $urandom;
            u0_kind  = 2'($urandom_range(0, 3));
            u0_taken = 1'($urandom_range(0, 1));
            u1_pc    = $urandom;
            u1_dest  = $urandom;
            u1_kind  = 2'($urandom_range(0, 3));
            u1_taken = 1'($urandom_range(0, 1));
        end
        if (checking) compare_outputs();
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic random_traffic(input int n);
        int drain_left;
        drain_left = 0;
        for (int i = 0; i < n; i++) begin
            if (drain_left == 0 && $urandom_range(0, 39) == 0) drain_left = $urandom_range(3, 15);
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, drain_left > 0);
            if (drain_left > 0) drain_left--;
        end
    endtask

    initial begin
        reset = 1'b1; u0_valid = 1'b0; u1_valid = 1'b0; stall = 1'b0; drain_req = 1'b0;
        u0_pc = '0; u0_dest = '0; u0_kind = '0; u0_taken = 1'b0;
        u1_pc = '0; u1_dest = '0; u1_kind = '0; u1_taken = 1'b0;

        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checking = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Sweep with random traffic and stall: every update is dropped
        for (int i = 0; i < SWEEP; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(3);

        // Directed dual update
        force0 = '{pc: 32'h8000_0100, dest: 32'h8000_0200, kind: 2'd0, taken: 1'b1};
        force1 = '{pc: 32'h8000_0104, dest: 32'h8000_0300, kind: 2'd2, taken: 1'b1};
        use_force = 1'b1;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(4);

        // Four entries queued under stall, held, then released
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(6);

        random_traffic(300);
        idle(6);

        // Full queue with both ports hammering: drop counter saturates
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(6);

        // Drain with entries queued
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, i == 2, 1'b1);
        idle(4);

        // Reset mid-traffic with writes in flight, then again mid-sweep
        random_traffic(40);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        random_traffic(60);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        random_traffic(SWEEP + 150);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
